// File: rtl/fifo_put_arbiter.sv
// Round-robin arbiter sharing the single FIFO write port among N_REQ producers.
// Each grant accepts at most MAX_BURST words; one idle cycle separates grants.
module fifo_put_arbiter #(
    parameter int N_REQ       = 4,
    parameter int ID_WIDTH    = 2,
    parameter int WIDTH       = 16,
    parameter int MAX_BURST   = 4,
    parameter int CNT_WIDTH   = 3,
    parameter int TOTAL_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]         ack,
    output logic                     fifo_put,
    output logic [WIDTH-1:0]         fifo_data,
    input  logic                     fifo_full_bar,
    output logic                     grant_valid,
    output logic [ID_WIDTH-1:0]      grant_id,
    output logic [TOTAL_WIDTH-1:0]   total_words
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                state, state_nxt;
    logic [ID_WIDTH-1:0]   last_owner, last_owner_nxt;
    logic [ID_WIDTH-1:0]   grant_id_nxt, pick;
    logic [CNT_WIDTH-1:0]  burst_cnt, burst_cnt_nxt;
    logic                  grant_valid_nxt, any_req;

    function automatic logic [TOTAL_WIDTH-1:0] sat_inc(input logic [TOTAL_WIDTH-1:0] v);
        return (&v) ? v : v + TOTAL_WIDTH'(1);
    endfunction

    // First requester found searching upward from the previous owner, with wrap.
    always_comb begin
        pick    = last_owner;
        any_req = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!any_req && req[(int'(last_owner) + k) % N_REQ]) begin
                pick    = ID_WIDTH'((int'(last_owner) + k) % N_REQ);
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        grant_valid_nxt = grant_valid;
        grant_id_nxt    = grant_id;
        last_owner_nxt  = last_owner;
        burst_cnt_nxt   = burst_cnt;
        fifo_put        = 1'b0;
        ack             = '0;
        fifo_data       = req_data[int'(grant_id)*WIDTH +: WIDTH];

        // Outputs are suppressed during reset so an aborted burst cannot leak a word.
        if (state == GRANT && !reset) begin
            fifo_put      = req[grant_id] & fifo_full_bar;
            ack[grant_id] = fifo_put;
        end

        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt       = GRANT;
                    grant_valid_nxt = 1'b1;
                    grant_id_nxt    = pick;
                    burst_cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (!req[grant_id]) begin
                    state_nxt       = IDLE;
                    grant_valid_nxt = 1'b0;
                    last_owner_nxt  = grant_id;
                end else if (fifo_put) begin
                    if (burst_cnt == CNT_WIDTH'(MAX_BURST - 1)) begin
                        state_nxt       = IDLE;
                        grant_valid_nxt = 1'b0;
                        last_owner_nxt  = grant_id;
                    end else begin
                        burst_cnt_nxt = burst_cnt + CNT_WIDTH'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            last_owner  <= ID_WIDTH'(N_REQ - 1);
            burst_cnt   <= '0;
            total_words <= '0;
        end else begin
            state       <= state_nxt;
            grant_valid <= grant_valid_nxt;
            grant_id    <= grant_id_nxt;
            last_owner  <= last_owner_nxt;
            burst_cnt   <= burst_cnt_nxt;
            if (fifo_put)
                total_words <= sat_inc(total_words);
        end
    end

endmodule

// File: tb/tb_fifo_put_arbiter.sv
// Directed bench for fifo_put_arbiter with a behavioural 8-deep FIFO on the write side.
`timescale 1ns/1ps
module tb_fifo_put_arbiter;

    localparam int N_REQ       = 4;
    localparam int ID_WIDTH    = 2;
    localparam int WIDTH       = 16;
    localparam int MAX_BURST   = 4;
    localparam int CNT_WIDTH   = 3;
    localparam int TOTAL_WIDTH = 16;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [N_REQ-1:0]       req = '0;
    logic [N_REQ*WIDTH-1:0] req_data = '0;
    logic [N_REQ-1:0]       ack;
    logic                   fifo_put;
    logic [WIDTH-1:0]       fifo_data;
    logic                   fifo_full_bar;
    logic                   grant_valid;
    logic [ID_WIDTH-1:0]    grant_id;
    logic [TOTAL_WIDTH-1:0] total_words;

    logic                   get = 1'b0;
    logic [WIDTH-1:0]       fifo_q[$];
    logic [WIDTH-1:0]       last_pop = '0;
    int                     fcount = 0;
    int                     acc_words = 0;
    int                     inv_viol = 0;
    int                     vectors = 0;
    int                     miscompares = 0;

    always #5 clk = ~clk;

    fifo_put_arbiter #(
        .N_REQ(N_REQ), .ID_WIDTH(ID_WIDTH), .WIDTH(WIDTH),
        .MAX_BURST(MAX_BURST), .CNT_WIDTH(CNT_WIDTH), .TOTAL_WIDTH(TOTAL_WIDTH)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
        .fifo_put(fifo_put), .fifo_data(fifo_data), .fifo_full_bar(fifo_full_bar),
        .grant_valid(grant_valid), .grant_id(grant_id), .total_words(total_words)
    );

    // FIFO model: registered full flag, read before write so an empty FIFO never pops.
    always @(posedge clk) begin
        if (get && fifo_q.size() > 0)
            last_pop = fifo_q.pop_front();
        if (fifo_put && fifo_full_bar) begin
            fifo_q.push_back(fifo_data);
            acc_words++;
        end
        fcount <= fifo_q.size();
    end
    assign fifo_full_bar = (fcount < 8);

    always @(negedge clk)
        if (fifo_put && !fifo_full_bar) inv_viol++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen34, seen35;
        seen34 = 1'b0;
        seen35 = 1'b0;

        // Reset state
        tick; tick; #1;
        chk("rst_gv", grant_valid, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_total", total_words, 0);
        chk("rst_put", fifo_put, 0);
        chk("rst_ack", ack, 0);

        // Single word from requester 0
        reset = 1'b0;
        req_data[0 +: WIDTH] = 16'h1111;
        req = 4'b0001;
        tick; #1;
        chk("t1_gv", grant_valid, 1);
        chk("t1_gid", grant_id, 0);
        chk("t1_put", fifo_put, 1);
        chk("t1_ack", ack, 4'b0001);
        chk("t1_data", fifo_data, 16'h1111);
        chk("t1_total_pre", total_words, 0);
        tick;
        req = 4'b0000;
        #1;
        chk("t1_put_wd", fifo_put, 0);
        chk("t1_total", total_words, 1);
        chk("t1_qsize", fifo_q.size(), 1);
        chk("t1_q0", fifo_q[0], 16'h1111);
        tick; #1;
        chk("t1_idle_gv", grant_valid, 0);
        chk("t1_idle_gid", grant_id, 0);

        // All four requesting, FIFO drained every cycle
        reset = 1'b1;
        get = 1'b1;
        tick;
        reset = 1'b0;
        req = 4'b1111;
        req_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        acc_words = 0;
        for (int j = 1; j <= 21; j++) begin
            tick; #1;
            if (j % 5 == 0) begin
                chk("rr_idle_gv", grant_valid, 0);
                chk("rr_idle_put", fifo_put, 0);
            end else begin
                chk("rr_put", fifo_put, 1);
                chk("rr_gid", grant_id, ((j - 1) / 5) % 4);
                chk("rr_ack", ack, 1 << (((j - 1) / 5) % 4));
                chk("rr_data", fifo_data, 16'hA000 + ((j - 1) / 5) % 4);
            end
        end
        chk("rr_accepted", acc_words, 16);
        chk("rr_total", total_words, 16);
        req = 4'b0000;
        #1;
        chk("rr_withdraw_put", fifo_put, 0);

        // FIFO fills while requester 2 owns the port
        tick; tick; tick;
        get = 1'b0;
        req = 4'b0100;
        req_data = '0;
        req_data[2*WIDTH +: WIDTH] = 16'h2000;
        for (int c = 0; c < 30 && fifo_q.size() < 8; c++) begin
            tick;
            req_data[2*WIDTH +: WIDTH] = 16'h2000 + 16'(fifo_q.size());
        end
        #1;
        chk("full_qsize", fifo_q.size(), 8);
        chk("full_flag", fifo_full_bar, 0);
        chk("full_idle_put", fifo_put, 0);
        tick; #1;
        chk("stall_gv", grant_valid, 1);
        chk("stall_gid", grant_id, 2);
        chk("stall_put", fifo_put, 0);
        chk("stall_ack", ack, 0);
        tick; #1;
        chk("stall2_gid", grant_id, 2);
        chk("stall2_put", fifo_put, 0);
        chk("stall2_total", total_words, 24);
        get = 1'b1;
        tick;
        get = 1'b0;
        #1;
        chk("resume_pop", last_pop, 16'h2000);
        chk("resume_put", fifo_put, 1);
        chk("resume_ack", ack, 4'b0100);
        chk("resume_data", fifo_data, 16'h2008);
        tick;
        req = 4'b0000;
        #1;
        for (int i = 0; i < 8; i++)
            chk("sb_word", fifo_q[i], 16'h2001 + i);
        chk("resume_total", total_words, 25);

        // Requester 1 withdraws mid-burst
        get = 1'b1;
        for (int c = 0; c < 11; c++) tick;
        req = 4'b0010;
        tick; #1;
        chk("wd_gid", grant_id, 1);
        chk("wd_put", fifo_put, 1);
        req = 4'b1011;
        tick; tick;
        req = 4'b1001;
        #1;
        chk("wd_put0", fifo_put, 0);
        chk("wd_ack0", ack, 0);
        chk("wd_total", total_words, 27);
        tick; #1;
        chk("wd_idle_gv", grant_valid, 0);
        chk("wd_idle_gid", grant_id, 1);
        tick; #1;
        chk("wd_next_gv", grant_valid, 1);
        chk("wd_next_gid", grant_id, 3);

        // Reset during a burst with two words already accepted
        tick; tick;
        chk("mid_total", total_words, 29);
        reset = 1'b1;
        #1;
        chk("mid_rst_put", fifo_put, 0);
        chk("mid_rst_ack", ack, 0);
        tick;
        reset = 1'b0;
        #1;
        chk("post_rst_gv", grant_valid, 0);
        chk("post_rst_gid", grant_id, 0);
        chk("post_rst_total", total_words, 0);
        chk("post_rst_put", fifo_put, 0);
        tick; #1;
        chk("post_rst_grant_gv", grant_valid, 1);
        chk("post_rst_grant_gid", grant_id, 0);

        // Saturation of the accepted-word counter
        reset = 1'b1;
        tick;
        reset = 1'b0;
        req = 4'b1111;
        get = 1'b1;
        acc_words = 0;
        for (int c = 0; c < 85000 && acc_words < 65540; c++) begin
            tick;
            if (acc_words == 65534 && !seen34) begin
                seen34 = 1'b1;
                chk("sat_fffe", total_words, 16'hFFFE);
            end
            if (acc_words == 65535 && !seen35) begin
                seen35 = 1'b1;
                chk("sat_ffff", total_words, 16'hFFFF);
            end
        end
        chk("sat_accepted", acc_words, 65540);
        chk("sat_hold", total_words, 16'hFFFF);
        chk("invariant_put_full", inv_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_put_arbiter.md
Name: fifo_put_arbiter

Overview:
- Shares one write port of the 8x16 FIFO among N_REQ producers using round-robin arbitration with bounded bursts.
- Drives FIFO put/data_in and observes FIFO full_bar. Returns a per-requester ack for every word the FIFO accepts.
- Sits directly in front of the FIFO write side. The FIFO read side is untouched.

Parameters:
- N_REQ, 4, number of requesters
- ID_WIDTH, 2, width of grant_id; must equal clog2(N_REQ)
- WIDTH, 16, data word width; must match the FIFO WIDTH
- MAX_BURST, 4, maximum words accepted per grant before priority rotates (1..7)
- CNT_WIDTH, 3, width of the burst counter; must hold MAX_BURST-1
- TOTAL_WIDTH, 16, width of the accepted-word counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  N_REQ  request per requester; held until ack or withdrawn
- req_data  input  N_REQ*WIDTH  flattened data; requester i uses bits [i*WIDTH +: WIDTH]
- ack  output  N_REQ  one-hot; word of requester i accepted this cycle
- fifo_put  output  1  to FIFO put
- fifo_data  output  WIDTH  to FIFO data_in
- fifo_full_bar  input  1  from FIFO full_bar; 0 means FIFO is full
- grant_valid  output  1  a requester currently owns the port
- grant_id  output  ID_WIDTH  current owner index; holds last owner when grant_valid=0
- total_words  output  TOTAL_WIDTH  saturating count of accepted words

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values (clk edge with reset=1): state=IDLE, grant_valid=0, grant_id=0, last_owner=N_REQ-1 (so requester 0 has first priority), burst_cnt=0, total_words=0. ack and fifo_put are combinational and are 0 whenever state=IDLE.
- Reset mid-burst: reset aborts the burst. No put or ack occurs in the reset cycle (outputs are forced 0 while reset=1).
- IDLE state:
  - No put.
  - If any req bit is set, pick the first set bit searching upward (with wrap) from last_owner+1.
  - Register owner into grant_id, set grant_valid=1, clear burst_cnt, go to GRANT.
  - Arbitration latency: 1 cycle from req to grant.
- GRANT state:
  - fifo_put = req[grant_id] & fifo_full_bar.
  - ack[grant_id] = fifo_put; all other ack bits are 0.
  - fifo_data = req_data slice of grant_id, always muxed, including non-put cycles.
- GRANT transitions (evaluated each clk):
  - req[grant_id]=0 (withdrawal): go to IDLE, last_owner<=grant_id, no put.
  - fifo_put=1 and burst_cnt==MAX_BURST-1: go to IDLE, last_owner<=grant_id (rotation).
  - fifo_put=1 otherwise: burst_cnt++, stay in GRANT.
  - req held with fifo_full_bar=0: stall. Stay in GRANT, burst_cnt unchanged, no ack. There is no timeout.
- Minimum spacing: one IDLE cycle separates consecutive grants.
  - Peak throughput is MAX_BURST words per MAX_BURST+1 cycles.
  - A single requester with continuous req gets back-to-back bursts separated by one IDLE cycle.
- FIFO full at put time: the FIFO discards puts while full, so fifo_put must never assert while fifo_full_bar=0. This is a hard invariant.
- Space freed by a same-cycle FIFO get is not visible until the FIFO flag updates. This is acceptable and causes at most one lost cycle.
- total_words: increments on every fifo_put and saturates at all-ones (no wrap).
- Requester obligation: keep req_data stable while req=1 and no ack. A new word may be presented the cycle after ack.
- Fairness bound: a requester holding req waits at most (N_REQ-1)*(MAX_BURST+1) accepted-or-stalled grant cycles plus FIFO-full stall time.

Test Plan:
- Reset then req=4'b0001, data 0x1111, FIFO empty -> grant in cycle 1, ack[0] and put in cycle 2 with fifo_data=0x1111, total_words=1.
- req=4'b1111 held, FIFO drained continuously -> grant order 0,1,2,3,0. Each owner gets exactly 4 puts, with one IDLE cycle between bursts.
- FIFO filled to 8 (full_bar=0) while requester 2 is granted -> fifo_put=0, ack=0, grant_id stays 2. Put resumes the first cycle full_bar=1 and no data is lost (scoreboard FIFO contents).
- Requester 1 withdraws req after 2 words -> IDLE next cycle, last_owner=1, and the next grant goes to the lowest set requester above 1 (with wrap).
- Reset asserted mid-burst (burst_cnt=2) -> same-cycle put and ack are 0. After release, state=IDLE, grant_id=0, total_words=0, and req=4'b1000 with 4'b0001 is granted to 0 first.
- Drive 65540 accepted words -> total_words saturates at 0xFFFF. Invariant checked throughout: fifo_put & ~fifo_full_bar is never 1.
